// File: rtl/updn_count_arb_pkg.sv
// Shared definitions for the up/down count arbiter: FSM encoding and default sizing.
package updn_count_arb_pkg;

  localparam int unsigned DefWidth = 3;
  localparam int unsigned DefBurst = 4;

  // Step counter is wide enough for the largest legal burst (15).
  localparam int unsigned StepWidth = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StRunUp = 2'd1;
  localparam state_t StRunDn = 2'd2;
  localparam state_t StTurn  = 2'd3;

  function automatic logic [StepWidth-1:0] last_step(input int unsigned burst);
    return StepWidth'(burst - 1);
  endfunction

endpackage

// File: rtl/updn_count_arb_if.sv
// Request/grant/count bundle between the two requesters and the arbiter.
interface updn_count_arb_if
  import updn_count_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) ();

  logic             req_up;
  logic             req_dn;
  logic [WIDTH-1:0] count;
  logic             gnt_up;
  logic             gnt_dn;
  logic             done;
  logic             busy;

  modport master (
    output req_up,
    output req_dn,
    input  count,
    input  gnt_up,
    input  gnt_dn,
    input  done,
    input  busy
  );

  modport slave (
    input  req_up,
    input  req_dn,
    output count,
    output gnt_up,
    output gnt_dn,
    output done,
    output busy
  );

endinterface

// File: rtl/updn_count_core.sv
// Shared count register: increments, decrements or holds; wraps modulo 2^WIDTH.
module updn_count_core
  import updn_count_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count;
    if (inc) begin
      count_d = count + WIDTH'(1);
    end else if (dec) begin
      count_d = count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/updn_count_arb.sv
// Round-robin arbiter granting fixed-length up or down count bursts on a shared counter.
module updn_count_arb
  import updn_count_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BURST = DefBurst
) (
  input logic             clk,
  input logic             rst,
  updn_count_arb_if.slave bus
);

  localparam logic [StepWidth-1:0] LastStep = last_step(BURST);

  state_t               state_q, state_d;
  logic [StepWidth-1:0] step_q, step_d;
  logic                 last_up_q, last_up_d;
  logic                 inc, dec;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_up_d = last_up_q;
    case (state_q)
      StIdle: begin
        // Up wins when alone, or when both request and down was served last.
        if (bus.req_up && (!bus.req_dn || !last_up_q)) begin
          state_d   = StRunUp;
          step_d    = '0;
          last_up_d = 1'b1;
        end else if (bus.req_dn) begin
          state_d   = StRunDn;
          step_d    = '0;
          last_up_d = 1'b0;
        end
      end
      StRunUp, StRunDn: begin
        if (step_q == LastStep) begin
          state_d = StTurn;
          step_d  = '0;
        end else begin
          step_d = step_q + StepWidth'(1);
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      step_q    <= '0;
      last_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      last_up_q <= last_up_d;
    end
  end

  // Steps are taken on every edge spent in a run state, including the one leaving it.
  assign inc = (state_q == StRunUp);
  assign dec = (state_q == StRunDn);

  updn_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .dec  (dec),
    .count(bus.count)
  );

  assign bus.gnt_up = (state_q == StRunUp);
  assign bus.gnt_dn = (state_q == StRunDn);
  assign bus.done   = (state_q == StTurn);
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_updn_count_arb.sv
// Directed bench for updn_count_arb: bursts, wrap-around, round-robin and reset abort.
module tb_updn_count_arb;
  import updn_count_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  updn_count_arb_if #(.WIDTH(3)) bus ();
  updn_count_arb_if #(.WIDTH(3)) bus2 ();

  updn_count_arb #(
    .WIDTH(3),
    .BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Second instance with a longer burst so the count can reach 6 before an up burst.
  updn_count_arb #(
    .WIDTH(3),
    .BURST(6)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int c, input logic gu, input logic gd,
                            input logic dn, input logic by);
    check({tag, ".count"}, 32'(bus.count), 32'(c));
    check({tag, ".gnt_up"}, 32'(bus.gnt_up), 32'(gu));
    check({tag, ".gnt_dn"}, 32'(bus.gnt_dn), 32'(gd));
    check({tag, ".done"}, 32'(bus.done), 32'(dn));
    check({tag, ".busy"}, 32'(bus.busy), 32'(by));
    check({tag, ".excl"}, 32'(bus.gnt_up & bus.gnt_dn), 32'd0);
  endtask

  task automatic expect_out2(input string tag, input int c, input logic gu, input logic dn);
    check({tag, ".count"}, 32'(bus2.count), 32'(c));
    check({tag, ".gnt_up"}, 32'(bus2.gnt_up), 32'(gu));
    check({tag, ".gnt_dn"}, 32'(bus2.gnt_dn), 32'd0);
    check({tag, ".done"}, 32'(bus2.done), 32'(dn));
  endtask

  // Entry cycle, BURST-1 further run cycles, TURN, IDLE; request must be set by the caller.
  task automatic run_burst(input string tag, input logic up, input int start, input logic drop);
    int c;
    tick();
    expect_out({tag, ".entry"}, start, up, !up, 1'b0, 1'b1);
    if (drop) begin
      if (up) bus.req_up = 1'b0;
      else    bus.req_dn = 1'b0;
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      c = up ? ((start + i) & 7) : ((start - i) & 7);
      expect_out({tag, ".step"}, c, up, !up, 1'b0, 1'b1);
    end
    c = up ? ((start + 4) & 7) : ((start - 4) & 7);
    tick();
    expect_out({tag, ".turn"}, c, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    expect_out({tag, ".idle"}, c, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_up  = 1'b0;
    bus.req_dn  = 1'b0;
    bus2.req_up = 1'b0;
    bus2.req_dn = 1'b0;
    tick();
    tick();
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle up request; burst completes although the request is dropped.
    rst = 1'b0;
    bus.req_up = 1'b1;
    run_burst("t1_up", 1'b1, 0, 1'b1);
    tick();
    expect_out("t1_hold", 4, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held down request: wrap 0->7 and back-to-back bursts with one idle cycle.
    rst = 1'b1;
    tick();
    expect_out("t2_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.req_dn = 1'b1;
    run_burst("t2_dn_a", 1'b0, 0, 1'b0);
    run_burst("t2_dn_b", 1'b0, 4, 1'b0);
    bus.req_dn = 1'b0;
    tick();
    expect_out("t2_end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both requesting from reset: up, dn, up, dn.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_up = 1'b1;
    bus.req_dn = 1'b1;
    run_burst("t3_up_a", 1'b1, 0, 1'b0);
    run_burst("t3_dn_a", 1'b0, 4, 1'b0);
    run_burst("t3_up_b", 1'b1, 0, 1'b0);
    run_burst("t3_dn_b", 1'b0, 4, 1'b0);
    bus.req_up = 1'b0;
    bus.req_dn = 1'b0;
    tick();
    expect_out("t3_end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during the second RUN_UP cycle abandons the burst without done.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_up = 1'b1;
    tick();
    expect_out("t4_entry", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.req_up = 1'b0;
    tick();
    expect_out("t4_step1", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    bus.req_up = 1'b1;
    tick();
    expect_out("t4_abort", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.req_up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t4_after", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Down then up on the main instance: up burst crosses 7->0.
    bus.req_dn = 1'b1;
    run_burst("t5_dn", 1'b0, 0, 1'b1);
    bus.req_up = 1'b1;
    run_burst("t5_up", 1'b1, 4, 1'b1);

    // BURST=6 instance: reach 6, then an up burst 7,0,1,2,3,4 with gnt_dn never high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus2.req_up = 1'b1;
    tick();
    expect_out2("t6_entry_a", 0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out2("t6_step_a", i, 1'b1, 1'b0);
    end
    tick();
    expect_out2("t6_turn_a", 6, 1'b0, 1'b1);
    tick();
    expect_out2("t6_idle_a", 6, 1'b0, 1'b0);
    tick();
    expect_out2("t6_entry_b", 6, 1'b1, 1'b0);
    bus2.req_up = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out2("t6_step_b", (6 + i) & 7, 1'b1, 1'b0);
    end
    tick();
    expect_out2("t6_turn_b", 4, 1'b0, 1'b1);
    tick();
    expect_out2("t6_idle_b", 4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
